// File: rtl/lsu_pkg.sv
// Shared types and helpers for the store-buffered load/store unit.
package lsu_pkg;

  // Width of addresses and data carried inside the store buffer.
  // The top-level ADDRESS_LENGTH is expected to equal this value.
  localparam int LSU_XLEN = 32;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_t;

  typedef struct packed {
    logic [LSU_XLEN-1:0] addr;
    mem_size_t           size;
    logic [LSU_XLEN-1:0] wdata;
  } sb_entry_t;

  // A half must sit on an even byte and a word on a 4-byte boundary.
  // The unused size encoding is always reported as misaligned.
  function automatic logic misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
    logic mis;
    case (size)
      BYTE:    mis = 1'b0;
      HALF:    mis = addr_lo[0];
      WORD:    mis = |addr_lo;
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/sb_fifo.sv
// Circular store-buffer FIFO. Every slot's occupancy flag and word address
// is exposed so the load path can detect read-after-write hazards.
module sb_fifo
  import lsu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push,
  input  sb_entry_t                         push_entry,
  input  logic                              pop,
  output sb_entry_t                         head_entry,
  output logic                              empty,
  output logic                              full,
  output logic [DEPTH-1:0]                  entry_valid,
  output logic [DEPTH-1:0][LSU_XLEN-3:0]    entry_word
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [PTR_W:0]   count_reg;
  logic [DEPTH-1:0] valid_reg;
  logic [DEPTH-1:0] valid_next;
  sb_entry_t        mem_reg [DEPTH];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop)  head_reg <= head_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Occupancy: a slot becomes live on push and dies when it is popped.
  always_comb begin
    valid_next = valid_reg;
    if (push) valid_next[tail_reg] = 1'b1;
    if (pop)  valid_next[head_reg] = 1'b0;
  end

  // Occupancy flag register; cleared so a reset discards pending stores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_reg <= '0;
    else        valid_reg <= valid_next;
  end

  // Payload storage carries no reset; occupancy flags qualify it.
  always_ff @(posedge clk) begin
    if (push) mem_reg[tail_reg] <= push_entry;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign entry_word[gi] = mem_reg[gi].addr[LSU_XLEN-1:2];
  end

  assign entry_valid = valid_reg;
  assign head_entry  = mem_reg[head_reg];
  assign empty       = (count_reg == '0);
  assign full        = (count_reg == (PTR_W+1)'(DEPTH));

endmodule

// File: rtl/store_buffer_lsu.sv
// Load/store front end: buffers stores ahead of the data RAM write port and
// serves loads from the RAM read port, stalling on same-word pending stores.
module store_buffer_lsu
  import lsu_pkg::*;
#(
  parameter int ADDRESS_LENGTH = 32,
  parameter int DEPTH          = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  input  logic                      req_store,
  input  logic [1:0]                req_size,
  input  logic                      req_unsigned,
  input  logic [ADDRESS_LENGTH-1:0] req_addr,
  input  logic [ADDRESS_LENGTH-1:0] req_wdata,
  output logic                      req_ready,
  output logic                      load_valid,
  output logic [ADDRESS_LENGTH-1:0] load_data,
  output logic                      misalign_err,
  input  logic                      wr_grant,
  output logic                      ram_sb,
  output logic                      ram_sh,
  output logic                      ram_sw,
  output logic [ADDRESS_LENGTH-1:0] ram_w_a,
  output logic [ADDRESS_LENGTH-1:0] ram_wd,
  output logic [ADDRESS_LENGTH-1:0] ram_r_a,
  input  logic [ADDRESS_LENGTH-1:0] ram_rd,
  output logic                      buf_empty
);

  sb_entry_t                        push_entry;
  sb_entry_t                        head_entry;
  logic                             fifo_empty;
  logic                             fifo_full;
  logic [DEPTH-1:0]                 entry_valid;
  logic [DEPTH-1:0][LSU_XLEN-3:0]   entry_word;
  logic [DEPTH-1:0]                 word_hit;
  logic                             load_hazard;
  logic                             is_mis;
  logic                             req_fire;
  logic                             load_fire;
  logic                             push;
  logic                             drain;
  logic [7:0]                       byte_sel;
  logic [15:0]                      half_sel;
  logic [ADDRESS_LENGTH-1:0]        load_ext;
  logic                             load_valid_reg;
  logic                             misalign_err_reg;
  logic [ADDRESS_LENGTH-1:0]        load_data_reg;

  assign is_mis = misaligned(req_addr[1:0], req_size);

  // A pending store to the same 32-bit word blocks a load, including the
  // entry that is draining this very cycle (no same-cycle bypass).
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hazard
    assign word_hit[gi] = entry_valid[gi] &&
                          (entry_word[gi] == req_addr[ADDRESS_LENGTH-1:2]);
  end
  assign load_hazard = |word_hit;

  assign req_ready = req_store ? !fifo_full : !load_hazard;
  assign req_fire  = req_valid && req_ready;
  assign load_fire = req_fire && !req_store;
  assign push      = req_fire && req_store && !is_mis;
  assign drain     = rst_n && !fifo_empty && wr_grant;

  // Pack the incoming store; only aligned stores are ever pushed.
  always_comb begin
    push_entry       = '0;
    push_entry.addr  = req_addr;
    push_entry.size  = mem_size_t'(req_size);
    push_entry.wdata = req_wdata;
  end

  sb_fifo #(
    .DEPTH (DEPTH)
  ) u_sb_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (drain),
    .head_entry  (head_entry),
    .empty       (fifo_empty),
    .full        (fifo_full),
    .entry_valid (entry_valid),
    .entry_word  (entry_word)
  );

  // Write strobe decode for the head entry; silent unless draining.
  always_comb begin
    ram_sb = 1'b0;
    ram_sh = 1'b0;
    ram_sw = 1'b0;
    if (drain) begin
      case (head_entry.size)
        BYTE:    ram_sb = 1'b1;
        HALF:    ram_sh = 1'b1;
        default: ram_sw = 1'b1;
      endcase
    end
  end

  assign ram_w_a   = head_entry.addr;
  assign ram_wd    = head_entry.wdata;
  assign ram_r_a   = req_addr;
  assign buf_empty = fifo_empty;

  // Lane select and sign/zero extension of the word returned by the RAM.
  always_comb begin
    case (req_addr[1:0])
      2'b00:   byte_sel = ram_rd[7:0];
      2'b01:   byte_sel = ram_rd[15:8];
      2'b10:   byte_sel = ram_rd[23:16];
      default: byte_sel = ram_rd[31:24];
    endcase
    half_sel = req_addr[1] ? ram_rd[31:16] : ram_rd[15:0];
    case (req_size)
      BYTE:    load_ext = {{(ADDRESS_LENGTH-8){~req_unsigned & byte_sel[7]}}, byte_sel};
      HALF:    load_ext = {{(ADDRESS_LENGTH-16){~req_unsigned & half_sel[15]}}, half_sel};
      default: load_ext = ram_rd;
    endcase
    if (is_mis) load_ext = '0;
  end

  // Load response register: one-cycle pulse per accepted load, with the
  // misalignment flag raised in the same slot for loads and stores alike.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_valid_reg   <= 1'b0;
      misalign_err_reg <= 1'b0;
      load_data_reg    <= '0;
    end else begin
      load_valid_reg   <= load_fire;
      misalign_err_reg <= req_fire && is_mis;
      if (load_fire) load_data_reg <= load_ext;
    end
  end

  assign load_valid   = load_valid_reg;
  assign misalign_err = misalign_err_reg;
  assign load_data    = load_data_reg;

endmodule

// File: tb/tb_store_buffer_lsu.sv
// Directed bench for store_buffer_lsu with a queue-based reference model and
// a byte-addressed RAM that commits the DUT's write strobes.
module tb_store_buffer_lsu;

  localparam int AW    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_store = 1'b0;
  logic [1:0]    req_size = 2'b00;
  logic          req_unsigned = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [AW-1:0] req_wdata = '0;
  logic          wr_grant = 1'b0;
  logic          req_ready, load_valid, misalign_err;
  logic [AW-1:0] load_data, ram_w_a, ram_wd, ram_r_a, ram_rd;
  logic          ram_sb, ram_sh, ram_sw, buf_empty;

  int n_checks = 0;
  int n_fail   = 0;

  store_buffer_lsu #(.ADDRESS_LENGTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .load_valid(load_valid),
    .load_data(load_data), .misalign_err(misalign_err), .wr_grant(wr_grant),
    .ram_sb(ram_sb), .ram_sh(ram_sh), .ram_sw(ram_sw), .ram_w_a(ram_w_a),
    .ram_wd(ram_wd), .ram_r_a(ram_r_a), .ram_rd(ram_rd), .buf_empty(buf_empty)
  );

  always #5 clk = ~clk;

  // ---------------- environment RAM (written by DUT strobes) ----------------
  logic [7:0] env_mem [256];
  logic       wp_sb = 1'b0, wp_sh = 1'b0, wp_sw = 1'b0;
  logic [31:0] wp_a = '0, wp_d = '0;

  assign ram_rd = {env_mem[{ram_r_a[7:2], 2'b11}], env_mem[{ram_r_a[7:2], 2'b10}],
                   env_mem[{ram_r_a[7:2], 2'b01}], env_mem[{ram_r_a[7:2], 2'b00}]};

  always @(posedge clk) begin
    if (wp_sb || wp_sh || wp_sw) env_mem[wp_a[7:0]] <= wp_d[7:0];
    if (wp_sh || wp_sw) env_mem[wp_a[7:0] + 8'd1] <= wp_d[15:8];
    if (wp_sw) begin
      env_mem[wp_a[7:0] + 8'd2] <= wp_d[23:16];
      env_mem[wp_a[7:0] + 8'd3] <= wp_d[31:24];
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] a;
    logic [1:0]  s;
    logic [31:0] d;
  } st_t;

  st_t         q[$];
  logic [7:0]  m_mem [256];
  logic        exp_lv = 1'b0;
  logic        exp_me = 1'b0;
  logic [31:0] exp_ld = '0;
  int          cyc = 0;

  function automatic logic model_mis(input logic [31:0] a, input logic [1:0] s);
    return (s == 2'd3) || ((a & ((32'd1 << s) - 32'd1)) != 32'd0);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] s, input logic u);
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] base;
    if (model_mis(a, s)) return 32'h0;
    if (s == 2'd0) begin
      b0 = m_mem[a[7:0]];
      return u ? {24'h0, b0} : {{24{b0[7]}}, b0};
    end else if (s == 2'd1) begin
      base = {a[7:1], 1'b0};
      b0 = m_mem[base];
      b1 = m_mem[base + 8'd1];
      return u ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
    end
    base = {a[7:2], 2'b00};
    b0 = m_mem[base]; b1 = m_mem[base + 8'd1];
    b2 = m_mem[base + 8'd2]; b3 = m_mem[base + 8'd3];
    return {b3, b2, b1, b0};
  endfunction

  // One compare pass per cycle, mid-cycle after inputs have settled.
  initial begin
    st_t  hd;
    logic haz, acc, mis, drn, esb, esh, esw, exp_rdy;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!rst_n) begin
        chk1("rst_sb", ram_sb, 1'b0);
        chk1("rst_sh", ram_sh, 1'b0);
        chk1("rst_sw", ram_sw, 1'b0);
        chk1("rst_buf_empty", buf_empty, 1'b1);
        chk1("rst_load_valid", load_valid, 1'b0);
        chk1("rst_misalign", misalign_err, 1'b0);
        chk32("rst_load_data", load_data, 32'h0);
        q.delete();
        exp_lv = 1'b0; exp_me = 1'b0; exp_ld = '0;
        wp_sb = 1'b0; wp_sh = 1'b0; wp_sw = 1'b0;
      end else begin
        haz = 1'b0;
        foreach (q[i]) if (q[i].a[31:2] == req_addr[31:2]) haz = 1'b1;
        exp_rdy = req_store ? (q.size() != DEPTH) : !haz;
        chk1("req_ready", req_ready, exp_rdy);
        chk1("buf_empty", buf_empty, q.size() == 0);
        chk32("ram_r_a", ram_r_a, req_addr);
        chk1("load_valid", load_valid, exp_lv);
        chk1("misalign_err", misalign_err, exp_me);
        if (exp_lv) chk32("load_data", load_data, exp_ld);

        drn = (q.size() != 0) && wr_grant;
        esb = 1'b0; esh = 1'b0; esw = 1'b0;
        if (drn) begin
          hd = q[0];
          esb = (hd.s == 2'd0); esh = (hd.s == 2'd1); esw = (hd.s == 2'd2);
        end
        chk1("ram_sb", ram_sb, esb);
        chk1("ram_sh", ram_sh, esh);
        chk1("ram_sw", ram_sw, esw);
        if (drn) begin
          chk32("ram_w_a", ram_w_a, hd.a);
          chk32("ram_wd", ram_wd, hd.d);
        end

        // The RAM commits whatever the DUT actually strobed this cycle.
        wp_sb = ram_sb; wp_sh = ram_sh; wp_sw = ram_sw;
        wp_a = ram_w_a; wp_d = ram_wd;

        acc = req_valid && exp_rdy;
        mis = model_mis(req_addr, req_size);
        exp_lv = acc && !req_store;
        exp_me = acc && mis;
        if (acc && !req_store) exp_ld = model_load(req_addr, req_size, req_unsigned);
        if (acc)
          $display("cyc %0d: accept %s size=%0d addr=%h wdata=%h mis=%0d", cyc,
                   req_store ? "store" : "load ", req_size, req_addr, req_wdata, mis);
        if (drn) begin
          m_mem[hd.a[7:0]] = hd.d[7:0];
          if (hd.s != 2'd0) m_mem[hd.a[7:0] + 8'd1] = hd.d[15:8];
          if (hd.s == 2'd2) begin
            m_mem[hd.a[7:0] + 8'd2] = hd.d[23:16];
            m_mem[hd.a[7:0] + 8'd3] = hd.d[31:24];
          end
          void'(q.pop_front());
          $display("cyc %0d: drain size=%0d addr=%h data=%h", cyc, hd.s, hd.a, hd.d);
        end
        if (acc && req_store && !mis) q.push_back('{a: req_addr, s: req_size, d: req_wdata});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic preload(input logic [7:0] idx, input logic [7:0] val);
    env_mem[idx] <= val;
    m_mem[idx] = val;
  endtask

  task automatic set_grant(input logic g);
    @(negedge clk);
    req_valid = 1'b0;
    wr_grant = g;
  endtask

  // Present a request and hold it until the DUT reports it will accept it.
  task automatic send(input logic st, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] d, input int max_wait);
    int waited;
    @(negedge clk);
    req_valid = 1'b1; req_store = st; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = d;
    waited = 0;
    #3;
    while (req_ready !== 1'b1 && waited < max_wait) begin
      @(negedge clk);
      #3;
      waited++;
    end
    if (req_ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL handshake_timeout: req_ready stayed %b, required 1 (addr %h)", req_ready, a);
    end
  endtask

  task automatic load_lit(input string nm, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] exp_v, input logic exp_mis);
    send(1'b0, sz, u, a, 32'h0, 20);
    @(negedge clk);
    req_valid = 1'b0;
    #3;
    chk1({nm, "_valid"}, load_valid, 1'b1);
    chk32({nm, "_data"}, load_data, exp_v);
    chk1({nm, "_mis"}, misalign_err, exp_mis);
  endtask

  task automatic wait_empty(input int max_wait);
    int c;
    c = 0;
    #3;
    while (buf_empty !== 1'b1 && c < max_wait) begin
      @(negedge clk);
      #3;
      c++;
    end
    if (buf_empty !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: buf_empty stayed %b, required 1", buf_empty);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 256; i++) preload(8'(i), 8'h00);
    preload(8'h00, 8'hFF); preload(8'h01, 8'h20); preload(8'h02, 8'h40); preload(8'h03, 8'h80);
    preload(8'h08, 8'hD8); preload(8'h09, 8'hC7); preload(8'h0A, 8'hB6); preload(8'h0B, 8'hA5);
    preload(8'h0C, 8'h3C); preload(8'h0D, 8'h56); preload(8'h0E, 8'h34); preload(8'h0F, 8'h12);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk1("post_reset_ready", req_ready, 1'b1);
    chk1("post_reset_empty", buf_empty, 1'b1);
    chk1("post_reset_lv", load_valid, 1'b0);
    chk32("post_reset_ld", load_data, 32'h0);

    // Basic loads against preloaded word 0x8040_20FF.
    load_lit("lw_10000", 2'd2, 1'b0, 32'h0001_0000, 32'h8040_20FF, 1'b0);
    load_lit("lb_10000", 2'd0, 1'b0, 32'h0001_0000, 32'hFFFF_FFFF, 1'b0);
    load_lit("lbu_10000", 2'd0, 1'b1, 32'h0001_0000, 32'h0000_00FF, 1'b0);
    load_lit("lh_10002", 2'd1, 1'b0, 32'h0001_0002, 32'hFFFF_8040, 1'b0);

    // Single store with grant: write one cycle after acceptance.
    set_grant(1'b1);
    send(1'b1, 2'd2, 1'b0, 32'h0001_0004, 32'hDEAD_BEEF, 5);
    @(negedge clk);
    req_valid = 1'b0;
    #3;
    chk1("sw_strobe", ram_sw, 1'b1);
    chk1("sw_no_sb", ram_sb, 1'b0);
    chk32("sw_addr", ram_w_a, 32'h0001_0004);
    chk32("sw_data", ram_wd, 32'hDEAD_BEEF);
    @(negedge clk);
    #3;
    chk1("sw_empty_after", buf_empty, 1'b1);
    load_lit("lw_10004", 2'd2, 1'b0, 32'h0001_0004, 32'hDEAD_BEEF, 1'b0);
    load_lit("lhu_10006", 2'd1, 1'b1, 32'h0001_0006, 32'h0000_DEAD, 1'b0);
    load_lit("lb_10005", 2'd0, 1'b0, 32'h0001_0005, 32'hFFFF_FFBE, 1'b0);

    // Fill the buffer with grant low, then release the grant.
    set_grant(1'b0);
    for (int i = 0; i < 4; i++) send(1'b1, 2'd2, 1'b0, 32'h0001_0020 + 32'(4 * i), 32'hA000_0000 + 32'(i), 5);
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b1; req_size = 2'd2;
    req_addr = 32'h0001_0030; req_wdata = 32'hA000_0004;
    #3;
    chk1("fifth_blocked", req_ready, 1'b0);
    @(negedge clk);
    wr_grant = 1'b1;
    #3;
    chk1("full_draining_blocked", req_ready, 1'b0);
    chk32("first_drain_addr", ram_w_a, 32'h0001_0020);
    @(negedge clk);
    #3;
    chk1("fifth_accepted", req_ready, 1'b1);
    chk32("second_drain_addr", ram_w_a, 32'h0001_0024);
    @(negedge clk);
    req_valid = 1'b0;
    wait_empty(20);
    load_lit("lw_10030", 2'd2, 1'b0, 32'h0001_0030, 32'hA000_0004, 1'b0);

    // Load hazard on a pending byte store in the same word.
    set_grant(1'b0);
    send(1'b1, 2'd0, 1'b0, 32'h0001_0009, 32'h0000_0011, 5);
    load_lit("lbu_1000c_nostall", 2'd0, 1'b1, 32'h0001_000C, 32'h0000_003C, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_size = 2'd0; req_unsigned = 1'b1;
    req_addr = 32'h0001_000B;
    #3;
    chk1("stall_0", req_ready, 1'b0);
    repeat (2) begin
      @(negedge clk);
      #3;
      chk1("stall_held", req_ready, 1'b0);
    end
    @(negedge clk);
    wr_grant = 1'b1;
    #3;
    chk1("stall_while_draining", req_ready, 1'b0);
    chk1("stall_drain_sb", ram_sb, 1'b1);
    @(negedge clk);
    #3;
    chk1("stall_release", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    #3;
    chk1("lbu_1000b_valid", load_valid, 1'b1);
    chk32("lbu_1000b_data", load_data, 32'h0000_00A5);
    load_lit("lw_10008_post_sb", 2'd2, 1'b0, 32'h0001_0008, 32'hA5B6_11D8, 1'b0);

    // Misaligned accesses.
    load_lit("lh_10001_mis", 2'd1, 1'b0, 32'h0001_0001, 32'h0, 1'b1);
    load_lit("size3_mis", 2'd3, 1'b0, 32'h0001_0000, 32'h0, 1'b1);
    send(1'b1, 2'd2, 1'b0, 32'h0001_0002, 32'h1234_5678, 5);
    @(negedge clk);
    req_valid = 1'b0;
    #3;
    chk1("sw_mis_err", misalign_err, 1'b1);
    chk1("sw_mis_no_lv", load_valid, 1'b0);
    chk1("sw_mis_no_strobe", ram_sw, 1'b0);
    chk1("sw_mis_empty", buf_empty, 1'b1);
    load_lit("lw_10000_unchanged", 2'd2, 1'b0, 32'h0001_0000, 32'h8040_20FF, 1'b0);

    // Reset with three stores pending: nothing may reach the RAM.
    set_grant(1'b0);
    for (int i = 0; i < 3; i++) send(1'b1, 2'd2, 1'b0, 32'h0001_0040 + 32'(4 * i), 32'h5500_0000 + 32'(i), 5);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    wr_grant = 1'b1;
    #3;
    chk1("midrst_sw", ram_sw, 1'b0);
    chk1("midrst_empty", buf_empty, 1'b1);
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    chk1("rel_empty", buf_empty, 1'b1);
    chk1("rel_ready", req_ready, 1'b1);
    chk1("rel_sw", ram_sw, 1'b0);
    repeat (3) @(negedge clk);
    load_lit("lw_10040_after_rst", 2'd2, 1'b0, 32'h0001_0040, 32'h0, 1'b0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/store_buffer_lsu.md
# store_buffer_lsu

Load/store front end placed directly upstream of the data RAM. It accepts one memory request per cycle from the execute stage. Stores go into a DEPTH-entry FIFO, which drains one entry per granted cycle onto the RAM's sb/sh/sw write port. Loads read the RAM's asynchronous read port and return sign- or zero-extended data one cycle later, stalling while the addressed word still has a store pending in the buffer.

## Interface
- ADDRESS_LENGTH, 32, address and data width
- DEPTH, 4, store buffer entries (power of two, ≥2)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_store  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word; 11 is illegal and treated as misaligned
- req_unsigned  in  1  loads only: zero-extend (lbu/lhu)
- req_addr  in  ADDRESS_LENGTH  byte address
- req_wdata  in  ADDRESS_LENGTH  store data, right-aligned
- req_ready  out  1  request accepted this cycle
- load_valid  out  1  load result valid
- load_data  out  ADDRESS_LENGTH  extended load result
- misalign_err  out  1  accepted request was misaligned
- wr_grant  in  1  RAM write port available this cycle
- ram_sb, ram_sh, ram_sw  out  1 each  one-hot write strobe to RAM, or all 0
- ram_w_a  out  ADDRESS_LENGTH  write byte address
- ram_wd  out  ADDRESS_LENGTH  write data
- ram_r_a  out  ADDRESS_LENGTH  read address; equals req_addr
- ram_rd  in  ADDRESS_LENGTH  word-aligned read data (combinational)
- buf_empty  out  1  no stores pending (for fence/halt)

## Operation
- Misaligned: half with addr[0]=1; word with addr[1:0]≠0; size 11.
  - Misaligned requests are accepted when req_ready would be 1.
  - A misaligned store is discarded.
  - A misaligned load gives load_valid=1, load_data=0.
  - Both cases raise misalign_err=1 for one cycle, aligned with where load_valid would be.
- Store: req_ready = !full. On acceptance, {addr, size, wdata} is pushed at the tail.
- Drain: when !empty and wr_grant, the head drives ram_w_a/ram_wd and the one strobe matching its size, combinationally; the head pops on that edge. Otherwise all strobes are 0.
- Load hazard: the load stalls (req_ready=0) while any valid entry has addr[31:2] equal to req_addr[31:2]. The entry draining this cycle still counts.
- Load issue: when there is no hazard, req_ready=1. On the next cycle load_valid=1 and load_data holds the extracted value:
  - byte lane = addr[1:0]; half lane = addr[1]
  - sign- or zero-extended per req_unsigned; word passes through.
- Push and pop in the same cycle: the count is unchanged and pointers wrap modulo DEPTH.
- Full and draining in the same cycle: req_ready stays 0. There is no same-cycle bypass.
- Stores drain in strict FIFO order.

## Timing
- Reset values: load_valid=0, load_data=0, misalign_err=0, all strobes 0, buf_empty=1, pointers and count 0.
- req_ready is 1 out of reset.
- Reset asserted mid-operation discards all pending stores. No RAM write occurs while rst_n=0.
- Store latency: accepted at edge N, the earliest RAM write is at edge N+1 (given wr_grant).
- Load latency: 1 cycle. load_valid is a registered single-cycle pulse per accepted load.
- Throughput: 1 request/cycle; 1 drain/cycle.

## Structure
- Package lsu_pkg:
  - typedef mem_size_t (BYTE=2'b00, HALF=2'b01, WORD=2'b10)
  - struct sb_entry_t {addr, size, wdata}
  - function misaligned(addr, size)
- One sub-module, sb_fifo: DEPTH-entry circular FIFO exposing all entries' valid/addr for hazard compare. Extraction and extension logic stay in the top.

## Test plan
- Reset, then lw at 0x10000 where RAM holds 0x8040_20FF → load_valid next cycle with load_data 0x8040_20FF. Then lb at 0x10000 → 0xFFFF_FFFF; lbu at 0x10000 → 0x0000_00FF; lh at 0x10002 → 0xFFFF_8040.
- sw 0xDEADBEEF to 0x10004 with wr_grant=1 → ram_sw=1, ram_w_a=0x10004, ram_wd=0xDEADBEEF exactly one cycle after acceptance; buf_empty returns to 1.
- wr_grant=0, issue 5 stores (DEPTH=4) → req_ready drops on the 5th. Raise wr_grant → drains occur in issue order, one per cycle, and the 5th store is accepted after the first pop.
- wr_grant=0, sb 0x11 to 0x10009, then lbu at 0x1000B → stall until wr_grant drains the sb, then load_data=0x0000_00xx reflecting post-store RAM. A load from 0x1000C does not stall.
- lh at 0x10001 → load_valid=1, load_data=0, misalign_err=1. sw at 0x10002 → misalign_err=1, no RAM strobe ever.
- Assert rst_n=0 with 3 stores pending → no strobes, buf_empty=1, req_ready=1 after release.
